// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a
// single full-subtractor cell and a registered borrow. A start/done handshake
// frames each operation; a new start is accepted in IDLE or in the DONE cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Counter must hold WIDTH after the final bit without wrapping.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             last;
  logic             accept;

  // Full-subtractor cell on the current operand LSBs and the stored borrow.
  always_comb begin
    d        = opa[0] ^ opb[0] ^ bin;
    bout     = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & bin);
    res_next = {d, res[WIDTH-1:1]};
    last     = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs; start is ignored while shifting.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
        else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      res <= '0;
      cnt <= '0;
      bin <= 1'b0;
    end
    else if (accept) begin
      opa <= a;
      opb <= b;
      res <= '0;
      cnt <= '0;
      bin <= 1'b0;
    end
    else if (state == SHIFT) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      res <= res_next;
      cnt <= cnt + 1'b1;
      bin <= bout;
    end
  end

  // Result outputs update only on the edge that processes the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b1;
    end
    else if ((state == SHIFT) && last) begin
      diff       <= res_next;
      borrow_out <= bout;
      zero       <= (res_next == '0);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 4-bit instance checked against
// plain-arithmetic expectations for difference, borrow, zero and timing.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8, zero8;
  logic       busy4, done4, borrow4, zero4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4), .zero(zero4)
  );

  always #5 clk = ~clk;

  // Present operands with start for exactly one accept edge.
  task automatic issue(input bit sel, input logic [7:0] av, input logic [7:0] bv);
    if (sel) begin
      start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0];
    end
    else begin
      start8 = 1'b1; a8 = av; b8 = bv;
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done; returns cycles since the accept edge, or -1.
  task automatic wait_done(input bit sel, output int cycles, output bit busy_all);
    busy_all = sel ? busy4 : busy8;
    cycles   = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (sel ? done4 : done8) return;
      busy_all = busy_all & (sel ? busy4 : busy8);
    end
    cycles = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
    total++; if (diff8 !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff8); end
    total++; if (borrow8 !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", borrow8); end
    total++; if (zero8 !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", zero8); end
    total++; if ({busy4, done4, diff4, borrow4, zero4} !== 8'b0000_0001) begin
      bad++; $display("FAIL reset_w4 got=%b want=00000001", {busy4, done4, diff4, borrow4, zero4});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit ball;
    issue(0, 8'h5A, 8'h1B);
    wait_done(0, cyc, ball);
    total++; if (cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", cyc); end
    total++; if (ball !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", ball); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy8); end
    total++; if (diff8 !== 8'h3F) begin bad++; $display("FAIL basic_diff got=%h want=3f", diff8); end
    total++; if (borrow8 !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b want=0", borrow8); end
    total++; if (zero8 !== 1'b0) begin bad++; $display("FAIL basic_zero got=%b want=0", zero8); end
    @(posedge clk); #1;
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done8); end
    total++; if (diff8 !== 8'h3F) begin bad++; $display("FAIL basic_hold got=%h want=3f", diff8); end
  endtask

  task automatic test_patterns();
    logic [7:0] ta [3] = '{8'h10, 8'h00, 8'h33};
    logic [7:0] tb [3] = '{8'h20, 8'hFF, 8'h33};
    logic [7:0] av, bv, ed;
    int cyc; bit ball;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) begin av = ta[i]; bv = tb[i]; end
      else begin av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255)); end
      ed = 8'((int'(av) - int'(bv)) & 255);
      issue(0, av, bv);
      wait_done(0, cyc, ball);
      total++;
      if (cyc !== 8) begin bad++; $display("FAIL pat_latency a=%h b=%h got=%0d want=8", av, bv, cyc); end
      total++;
      if (diff8 !== ed) begin bad++; $display("FAIL pat_diff a=%h b=%h got=%h want=%h", av, bv, diff8, ed); end
      total++;
      if (borrow8 !== (av < bv)) begin bad++; $display("FAIL pat_borrow a=%h b=%h got=%b want=%b", av, bv, borrow8, av < bv); end
      total++;
      if (zero8 !== (ed == 8'h00)) begin bad++; $display("FAIL pat_zero a=%h b=%h got=%b want=%b", av, bv, zero8, ed == 8'h00); end
      @(posedge clk); #1;
    end
    // Leave 0x33 - 0x33 as the held result for the next test.
    issue(0, 8'h33, 8'h33);
    wait_done(0, cyc, ball);
    total++; if (zero8 !== 1'b1) begin bad++; $display("FAIL pat_zero_final got=%b want=1", zero8); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int cyc; bit ball;
    issue(0, 8'h80, 8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    total++; if (diff8 !== 8'h00) begin bad++; $display("FAIL ign_hold_diff got=%h want=00", diff8); end
    total++; if (zero8 !== 1'b1) begin bad++; $display("FAIL ign_hold_zero got=%b want=1", zero8); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", busy8); end
    wait_done(0, cyc, ball);
    total++; if (cyc !== 5) begin bad++; $display("FAIL ign_latency got=%0d want=5", cyc); end
    total++; if (diff8 !== 8'h7F) begin bad++; $display("FAIL ign_diff got=%h want=7f", diff8); end
    total++; if (borrow8 !== 1'b0) begin bad++; $display("FAIL ign_borrow got=%b want=0", borrow8); end
    @(posedge clk); #1;
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL ign_no_rerun got=%b want=0", done8); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit ball; int seen;
    issue(0, 8'h40, 8'h04);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    total++; if ({busy8, done8, borrow8} !== 3'b000) begin bad++; $display("FAIL abort_ctrl got=%b want=000", {busy8, done8, borrow8}); end
    total++; if (diff8 !== 8'h00) begin bad++; $display("FAIL abort_diff got=%h want=00", diff8); end
    total++; if (zero8 !== 1'b1) begin bad++; $display("FAIL abort_zero got=%b want=1", zero8); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 === 1'b1 || busy8 === 1'b1) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    issue(0, 8'h40, 8'h04);
    wait_done(0, cyc, ball);
    total++; if (cyc !== 8) begin bad++; $display("FAIL abort_restart_latency got=%0d want=8", cyc); end
    total++; if (diff8 !== 8'h3C) begin bad++; $display("FAIL abort_restart_diff got=%h want=3c", diff8); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$], qb[$];
    logic [7:0] av, bv, ed;
    int since, ndone;
    av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255));
    start8 = 1'b1; a8 = av; b8 = bv; qa.push_back(av); qb.push_back(bv);
    since = -1; ndone = 0;
    for (int i = 0; i < 100 && ndone < 5; i++) begin
      @(posedge clk); #1;
      since++;
      if (done8 === 1'b1) begin
        av = qa.pop_front(); bv = qb.pop_front();
        ed = 8'((int'(av) - int'(bv)) & 255);
        total++;
        if (since !== (ndone == 0 ? 8 : 9)) begin
          bad++; $display("FAIL b2b_interval op=%0d got=%0d want=%0d", ndone, since, (ndone == 0 ? 8 : 9));
        end
        total++;
        if (diff8 !== ed || borrow8 !== (av < bv)) begin
          bad++; $display("FAIL b2b_result op=%0d a=%h b=%h got=%h/%b want=%h/%b", ndone, av, bv, diff8, borrow8, ed, av < bv);
        end
        ndone++;
        since = 0;
        if (ndone < 5) begin
          av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255));
          a8 = av; b8 = bv; qa.push_back(av); qb.push_back(bv);
        end
        else begin
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    total++; if (ndone !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", ndone); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4();
    int cyc; bit ball;
    logic [3:0] ed;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        ed = 4'((x - y) & 15);
        issue(1, 8'(x), 8'(y));
        wait_done(1, cyc, ball);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL w4_latency a=%0d b=%0d got=%0d want=4", x, y, cyc); end
        total++;
        if (diff4 !== ed || borrow4 !== (x < y) || zero4 !== (ed == 4'd0)) begin
          bad++; $display("FAIL w4_result a=%0d b=%0d got=%h/%b/%b want=%h/%b/%b", x, y, diff4, borrow4, zero4, ed, x < y, ed == 4'd0);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
